// File: rtl/leve1_div_seq.sv
// Sequential restoring radix-2 integer divider for the RV64M DIV/REM family.
// One quotient bit per cycle; divide-by-zero, overflow and invalid ops finish in one cycle.
module leve1_div_seq #(
  parameter int XLEN = 64
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            IVALID,
  output logic            IREADY,
  input  logic [2:0]      IFUNCT3,
  input  logic            IW,
  input  logic [XLEN-1:0] IRS1,
  input  logic [XLEN-1:0] IRS2,
  input  logic            IFLUSH,
  output logic            OVALID,
  input  logic            OREADY,
  output logic [XLEN-1:0] ORESULT,
  output logic            BUSY
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    sext32 = XLEN'($signed(v));
  endfunction

  function automatic logic [XLEN-1:0] fmt_res(input logic [XLEN-1:0] v, input logic w);
    fmt_res = w ? sext32(v[31:0]) : v;
  endfunction

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] res_q, res_d;
  logic            w_q, w_d;
  logic            rem_op_q, rem_op_d;
  logic            neg_q_q, neg_q_d;
  logic            neg_r_q, neg_r_d;

  logic            is_signed_s, a_neg_s, b_neg_s, div_zero_s, ovf_s;
  logic [XLEN-1:0] a_ext_s, b_ext_s, a_mag_s, b_mag_s, min_s;
  logic [XLEN:0]   rem_sh_s, diff_s;
  logic            ge_s;
  logic [XLEN-1:0] rem_nx_s, quo_nx_s, q_fin_s, r_fin_s;
  logic [CW-1:0]   last_s;

  // Operand conditioning at the request port: width select, sign handling, special cases.
  always_comb begin
    is_signed_s = ~IFUNCT3[0];
    if (IW) begin
      a_ext_s = is_signed_s ? sext32(IRS1[31:0]) : XLEN'(IRS1[31:0]);
      b_ext_s = is_signed_s ? sext32(IRS2[31:0]) : XLEN'(IRS2[31:0]);
      min_s   = sext32(32'h8000_0000);
    end else begin
      a_ext_s = IRS1;
      b_ext_s = IRS2;
      min_s   = {1'b1, {(XLEN-1){1'b0}}};
    end
    a_neg_s    = is_signed_s & a_ext_s[XLEN-1];
    b_neg_s    = is_signed_s & b_ext_s[XLEN-1];
    a_mag_s    = a_neg_s ? -a_ext_s : a_ext_s;
    b_mag_s    = b_neg_s ? -b_ext_s : b_ext_s;
    div_zero_s = (b_ext_s == '0);
    ovf_s      = is_signed_s && (a_ext_s == min_s) && (b_ext_s == '1);
  end

  // One restoring step plus the sign fix-up applied on the final step.
  always_comb begin
    rem_sh_s = {rem_q, quo_q[XLEN-1]};
    diff_s   = rem_sh_s - {1'b0, dvs_q};
    ge_s     = ~diff_s[XLEN];
    rem_nx_s = ge_s ? diff_s[XLEN-1:0] : rem_sh_s[XLEN-1:0];
    quo_nx_s = {quo_q[XLEN-2:0], ge_s};
    q_fin_s  = neg_q_q ? -quo_nx_s : quo_nx_s;
    r_fin_s  = neg_r_q ? -rem_nx_s : rem_nx_s;
    last_s   = w_q ? CW'(31) : CW'(XLEN - 1);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    res_d    = res_q;
    w_d      = w_q;
    rem_op_d = rem_op_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    if (IFLUSH) begin
      state_d = IDLE;
      cnt_d   = '0;
      res_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (IVALID) begin
            w_d      = IW;
            rem_op_d = IFUNCT3[1];
            neg_q_d  = a_neg_s ^ b_neg_s;
            neg_r_d  = a_neg_s;
            cnt_d    = '0;
            rem_d    = '0;
            dvs_d    = b_mag_s;
            // Word operands are left-aligned so the loop only needs 32 steps.
            quo_d    = IW ? (a_mag_s << (XLEN - 32)) : a_mag_s;
            if (!IFUNCT3[2]) begin
              res_d   = '0;
              state_d = DONE;
            end else if (div_zero_s) begin
              res_d   = fmt_res(IFUNCT3[1] ? a_ext_s : '1, IW);
              state_d = DONE;
            end else if (ovf_s) begin
              res_d   = fmt_res(IFUNCT3[1] ? '0 : a_ext_s, IW);
              state_d = DONE;
            end else begin
              state_d = CALC;
            end
          end else begin
            state_d = IDLE;
          end
        end
        CALC: begin
          rem_d = rem_nx_s;
          quo_d = quo_nx_s;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == last_s) begin
            res_d   = fmt_res(rem_op_q ? r_fin_s : q_fin_s, w_q);
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
        DONE: begin
          if (OREADY) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      res_q    <= '0;
      w_q      <= 1'b0;
      rem_op_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      res_q    <= res_d;
      w_q      <= w_d;
      rem_op_q <= rem_op_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
    end
  end

  assign IREADY  = (state_q == IDLE);
  assign OVALID  = (state_q == DONE);
  assign BUSY    = (state_q != IDLE);
  assign ORESULT = res_q;

endmodule

// File: tb/tb_leve1_div_seq.sv
// Directed bench for leve1_div_seq: hand-computed results and latencies per scenario.
module tb_leve1_div_seq;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        IVALID;
  logic        IREADY;
  logic [2:0]  IFUNCT3;
  logic        IW;
  logic [63:0] IRS1;
  logic [63:0] IRS2;
  logic        IFLUSH;
  logic        OVALID;
  logic        OREADY;
  logic [63:0] ORESULT;
  logic        BUSY;

  int total = 0;
  int bad   = 0;

  localparam logic [2:0] F_DIV  = 3'b100;
  localparam logic [2:0] F_DIVU = 3'b101;
  localparam logic [2:0] F_REM  = 3'b110;
  localparam logic [2:0] F_REMU = 3'b111;

  leve1_div_seq #(.XLEN(64)) dut (
    .CLK(CLK), .RSTn(RSTn), .IVALID(IVALID), .IREADY(IREADY), .IFUNCT3(IFUNCT3),
    .IW(IW), .IRS1(IRS1), .IRS2(IRS2), .IFLUSH(IFLUSH), .OVALID(OVALID),
    .OREADY(OREADY), .ORESULT(ORESULT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Issue one request, scramble inputs after acceptance, wait (bounded) for the result, consume it.
  task automatic run_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                        input logic [63:0] b, output int lat, output logic [63:0] res);
    IFUNCT3 = f3; IW = w; IRS1 = a; IRS2 = b; IVALID = 1'b1;
    @(posedge CLK); #1;
    IVALID = 1'b0; IFUNCT3 = 3'b000; IW = ~w; IRS1 = ~a; IRS2 = 64'h0;
    lat = -1;
    for (int n = 0; n < 200; n++) begin
      if (OVALID) begin
        lat = n;
        break;
      end
      @(posedge CLK); #1;
    end
    res = ORESULT;
    OREADY = 1'b1;
    @(posedge CLK); #1;
    OREADY = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (IREADY !== 1'b1) begin bad++; $display("FAIL rst_iready got=%b want=1", IREADY); end
    total++; if (OVALID !== 1'b0) begin bad++; $display("FAIL rst_ovalid got=%b want=0", OVALID); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", BUSY); end
    total++; if (ORESULT !== 64'h0) begin bad++; $display("FAIL rst_result got=%h want=0", ORESULT); end
  endtask

  task automatic test_signed();
    int lat; logic [63:0] res;
    run_op(F_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, lat, res);
    total++; if (lat !== 64) begin bad++; $display("FAIL div_lat got=%0d want=64", lat); end
    total++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin bad++; $display("FAIL div_res got=%h want=fffffffffffffffd", res); end
    run_op(F_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, lat, res);
    total++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL rem_res got=%h want=ffffffffffffffff", res); end
    run_op(F_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, lat, res);
    total++; if (res !== 64'd3) begin bad++; $display("FAIL div_negneg got=%h want=3", res); end
    run_op(F_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, lat, res);
    total++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL rem_negneg got=%h want=ffffffffffffffff", res); end
  endtask

  task automatic test_unsigned();
    int lat; logic [63:0] res;
    run_op(F_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, lat, res);
    total++; if (res !== 64'h5555_5555_5555_5555) begin bad++; $display("FAIL divu_big got=%h want=5555555555555555", res); end
    total++; if (lat !== 64) begin bad++; $display("FAIL divu_lat got=%0d want=64", lat); end
    run_op(F_REMU, 1'b0, 64'd100, 64'd7, lat, res);
    total++; if (res !== 64'd2) begin bad++; $display("FAIL remu_small got=%h want=2", res); end
  endtask

  task automatic test_div_zero();
    int lat; logic [63:0] res;
    run_op(F_DIVU, 1'b0, 64'h1234, 64'h0, lat, res);
    total++; if (lat !== 0) begin bad++; $display("FAIL dz_lat got=%0d want=0", lat); end
    total++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL dz_divu got=%h want=ffffffffffffffff", res); end
    run_op(F_REMU, 1'b0, 64'h1234, 64'h0, lat, res);
    total++; if (res !== 64'h1234) begin bad++; $display("FAIL dz_remu got=%h want=1234", res); end
    run_op(F_REMU, 1'b1, 64'h1234_5678_8000_0001, 64'hFFFF_FFFF_0000_0000, lat, res);
    total++; if (res !== 64'hFFFF_FFFF_8000_0001) begin bad++; $display("FAIL dz_remuw got=%h want=ffffffff80000001", res); end
    total++; if (lat !== 0) begin bad++; $display("FAIL dz_w_lat got=%0d want=0", lat); end
  endtask

  task automatic test_overflow();
    int lat; logic [63:0] res;
    run_op(F_DIV, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, lat, res);
    total++; if (lat !== 0) begin bad++; $display("FAIL ovf_lat got=%0d want=0", lat); end
    total++; if (res !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL ovf_div got=%h want=8000000000000000", res); end
    run_op(F_REM, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, lat, res);
    total++; if (res !== 64'h0) begin bad++; $display("FAIL ovf_rem got=%h want=0", res); end
    run_op(F_DIV, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, lat, res);
    total++; if (res !== 64'hFFFF_FFFF_8000_0000) begin bad++; $display("FAIL ovf_divw got=%h want=ffffffff80000000", res); end
  endtask

  task automatic test_word();
    int lat; logic [63:0] res;
    run_op(F_DIVU, 1'b1, 64'hAAAA_AAAA_FFFF_FFFE, 64'd1, lat, res);
    total++; if (lat !== 32) begin bad++; $display("FAIL divuw_lat got=%0d want=32", lat); end
    total++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin bad++; $display("FAIL divuw_res got=%h want=fffffffffffffffe", res); end
    run_op(F_DIV, 1'b1, 64'h1111_0000_FFFF_FFF9, 64'h2222_0000_0000_0002, lat, res);
    total++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin bad++; $display("FAIL divw_res got=%h want=fffffffffffffffd", res); end
    run_op(F_REM, 1'b1, 64'd7, 64'h0000_0000_FFFF_FFFE, lat, res);
    total++; if (res !== 64'd1) begin bad++; $display("FAIL remw_res got=%h want=1", res); end
  endtask

  task automatic test_invalid();
    int lat; logic [63:0] res;
    run_op(3'b011, 1'b0, 64'd5, 64'd1, lat, res);
    total++; if (res !== 64'h0) begin bad++; $display("FAIL inv_res got=%h want=0", res); end
    total++; if (lat !== 0) begin bad++; $display("FAIL inv_lat got=%0d want=0", lat); end
  endtask

  task automatic test_flush();
    int lat; logic [63:0] res; logic seen;
    IFUNCT3 = F_DIVU; IW = 1'b0; IRS1 = 64'd100; IRS2 = 64'd7; IVALID = 1'b1;
    @(posedge CLK); #1;
    IVALID = 1'b0;
    repeat (9) begin @(posedge CLK); #1; end
    IFLUSH = 1'b1;
    @(posedge CLK); #1;
    IFLUSH = 1'b0;
    total++; if (IREADY !== 1'b1) begin bad++; $display("FAIL flush_iready got=%b want=1", IREADY); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b want=0", BUSY); end
    seen = 1'b0;
    repeat (80) begin
      if (OVALID) seen = 1'b1;
      @(posedge CLK); #1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_ovalid got=%b want=0", seen); end
    IVALID = 1'b1; IFLUSH = 1'b1;
    @(posedge CLK); #1;
    IVALID = 1'b0; IFLUSH = 1'b0;
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL flush_noaccept got=%b want=0", BUSY); end
    run_op(F_DIVU, 1'b0, 64'd100, 64'd7, lat, res);
    total++; if (res !== 64'd14) begin bad++; $display("FAIL flush_after got=%h want=e", res); end
    total++; if (lat !== 64) begin bad++; $display("FAIL flush_after_lat got=%0d want=64", lat); end
  endtask

  task automatic test_hold();
    int lat;
    IFUNCT3 = F_DIVU; IW = 1'b0; IRS1 = 64'd100; IRS2 = 64'd7; IVALID = 1'b1;
    @(posedge CLK); #1;
    IVALID = 1'b0;
    lat = -1;
    for (int n = 0; n < 200; n++) begin
      if (OVALID) begin
        lat = n;
        break;
      end
      @(posedge CLK); #1;
    end
    total++; if (lat !== 64) begin bad++; $display("FAIL hold_lat got=%0d want=64", lat); end
    IVALID = 1'b1; IRS1 = 64'd9; IRS2 = 64'd3;
    for (int c = 0; c < 5; c++) begin
      total++;
      if (OVALID !== 1'b1 || ORESULT !== 64'd14 || IREADY !== 1'b0 || BUSY !== 1'b1) begin
        bad++;
        $display("FAIL hold_c%0d got ov=%b res=%h ir=%b busy=%b want ov=1 res=e ir=0 busy=1",
                 c, OVALID, ORESULT, IREADY, BUSY);
      end
      @(posedge CLK); #1;
    end
    OREADY = 1'b1;
    @(posedge CLK); #1;
    OREADY = 1'b0; IVALID = 1'b0;
    total++; if (OVALID !== 1'b0 || IREADY !== 1'b1) begin bad++; $display("FAIL hold_release got ov=%b ir=%b want ov=0 ir=1", OVALID, IREADY); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [63:0] res;
    IFUNCT3 = F_DIV; IW = 1'b0; IRS1 = 64'hFFFF_FFFF_FFFF_FFF9; IRS2 = 64'd2; IVALID = 1'b1;
    @(posedge CLK); #1;
    IVALID = 1'b0;
    repeat (20) begin @(posedge CLK); #1; end
    #2 RSTn = 1'b0;
    #1;
    total++;
    if (IREADY !== 1'b1 || OVALID !== 1'b0 || BUSY !== 1'b0 || ORESULT !== 64'h0) begin
      bad++;
      $display("FAIL midrst got ir=%b ov=%b busy=%b res=%h want ir=1 ov=0 busy=0 res=0",
               IREADY, OVALID, BUSY, ORESULT);
    end
    @(negedge CLK);
    RSTn = 1'b1;
    @(posedge CLK); #1;
    run_op(F_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, lat, res);
    total++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin bad++; $display("FAIL midrst_after got=%h want=fffffffffffffffd", res); end
    total++; if (lat !== 64) begin bad++; $display("FAIL midrst_lat got=%0d want=64", lat); end
  endtask

  initial begin
    RSTn = 1'b0; IVALID = 1'b0; IFUNCT3 = 3'b000; IW = 1'b0;
    IRS1 = 64'h0; IRS2 = 64'h0; IFLUSH = 1'b0; OREADY = 1'b0;
    #12;
    test_reset();
    @(negedge CLK);
    RSTn = 1'b1;
    @(posedge CLK); #1;
    test_signed();
    test_unsigned();
    test_div_zero();
    test_overflow();
    test_word();
    test_invalid();
    test_flush();
    test_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
